// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch-stage state encoding and PC increment.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of fetch-stage signals; fu is the block side, tb drives memories and control.
interface fetch_unit_if #(
    parameter int unsigned WORD_W = 32
) (
    input logic CLK
);
    logic              RST;
    logic              ihit;
    logic [WORD_W-1:0] iload;
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              dmem_req;
    logic              dhit;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              halt;
    logic [WORD_W-1:0] Instr;
    logic              instr_valid;
    logic [WORD_W-1:0] pc_out;
    logic [WORD_W-1:0] npc_out;
    logic              halted;

    modport fu (
        input  CLK, RST, ihit, iload, dmem_req, dhit, redirect, redirect_pc, halt,
        output imemREN, imemaddr, Instr, instr_valid, pc_out, npc_out, halted
    );

    modport tb (
        input  CLK, imemREN, imemaddr, Instr, instr_valid, pc_out, npc_out, halted,
        output RST, ihit, iload, dmem_req, dhit, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter: sync reset to a word-aligned PC_INIT, loads redirect target or PC+4.
module pc_register
    import cpu_types_pkg::*;
#(
    parameter int unsigned         WORD_W  = 32,
    parameter logic [WORD_W-1:0]   PC_INIT = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              redirect_i,
    input  logic [WORD_W-1:0] redirect_pc_i,
    output logic [WORD_W-1:0] pc_o
);

    localparam logic [WORD_W-1:0] ALIGN_MASK = ~WORD_W'(3);

    logic [WORD_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = redirect_i ? (redirect_pc_i & ALIGN_MASK) : (pc_q + WORD_W'(PC_STEP));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= PC_INIT & ALIGN_MASK;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, instruction register and FETCH/EXEC/HALTED control.
// Optional FETCH_STATS_EN adds retired_cnt / stall_cnt counters.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned       WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic              dmem_req,
    input  logic              dhit,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [WORD_W-1:0] Instr,
    output logic              instr_valid,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] npc_out,
    output logic              halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pcout_q, pcout_d;
    logic [WORD_W-1:0] pc;
    logic              retire;
    logic              pc_load;

    assign retire = !dmem_req || dhit;

    pc_register #(
        .WORD_W  (WORD_W),
        .PC_INIT (PC_INIT)
    ) u_pc (
        .clk_i         (CLK),
        .rst_i         (RST),
        .load_i        (pc_load),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        pc_load = 1'b0;
        case (state_q)
            FETCH: begin
                if (ihit) begin
                    instr_d = iload;
                    pcout_d = pc;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Halt takes priority over redirect and leaves the PC untouched.
                if (retire) begin
                    if (halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_load = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: ;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            instr_q <= '0;
            pcout_q <= PC_INIT;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
        end
    end

    assign imemREN     = (state_q == FETCH);
    assign imemaddr    = pc;
    assign instr_valid = (state_q == EXEC);
    assign halted      = (state_q == HALTED);
    assign Instr       = instr_q;
    assign pc_out      = pcout_q;
    assign npc_out     = pcout_q + WORD_W'(PC_STEP);

`ifdef FETCH_STATS_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        retired_d = retired_q;
        stall_d   = stall_q;
        if (state_q == EXEC && retire) begin
            retired_d = retired_q + 32'd1;
        end
        if ((state_q == FETCH && !ihit) || (state_q == EXEC && !retire)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit; stats checks compile in with FETCH_STATS_EN.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST, ihit, dmem_req, dhit, redirect, halt;
    word_t iload, redirect_pc;
    logic  imemREN, instr_valid, halted;
    word_t imemaddr, Instr, pc_out, npc_out;
`ifdef FETCH_STATS_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fetch_unit #(
        .WORD_W  (32),
        .PC_INIT (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .iload       (iload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .dmem_req    (dmem_req),
        .dhit        (dhit),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .Instr       (Instr),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .npc_out     (npc_out),
        .halted      (halted)
`ifdef FETCH_STATS_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    typedef struct {
        logic  rst, ihit;
        word_t iload;
        logic  dreq, dhit, redir;
        word_t rpc;
        logic  halt;
        logic  e_ren;
        word_t e_addr;
        logic  e_valid;
        word_t e_instr, e_pc, e_npc;
        logic  e_halted;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic ih, word_t il, logic dr, logic dh,
                                logic rd, word_t rp, logic hl, logic ren, word_t addr,
                                logic vld, word_t ins, word_t pc, word_t npc, logic hd);
        vec_t v;
        v.rst = rst; v.ihit = ih; v.iload = il; v.dreq = dr; v.dhit = dh;
        v.redir = rd; v.rpc = rp; v.halt = hl;
        v.e_ren = ren; v.e_addr = addr; v.e_valid = vld; v.e_instr = ins;
        v.e_pc = pc; v.e_npc = npc; v.e_halted = hd;
        return v;
    endfunction

    task automatic chk(string name, word_t act, word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic ih, word_t il, logic dr, logic dh,
                         logic rd, word_t rp, logic hl);
        RST = rst; ihit = ih; iload = il; dmem_req = dr; dhit = dh;
        redirect = rd; redirect_pc = rp; halt = hl;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        word_t exp_pc;
        bit    found;

        drive(1, 0, '0, 0, 0, 0, '0, 0);

        //             rst ih iload         dr dh rd rpc           hl | ren addr          v  instr         pc            npc           h
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h0,        0,  1, 32'h0,        0, 32'h0,        32'h0,        32'h4,        0));
        vecs.push_back(mk(0, 1, 32'h2001_0005,0, 0, 0, 32'h0,        0,  0, 32'h0,        1, 32'h2001_0005,32'h0,        32'h4,        0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  1, 32'h4,        0, 32'h2001_0005,32'h0,        32'h4,        0));
        vecs.push_back(mk(0, 1, 32'h2001_0005,0, 0, 0, 32'h0,        0,  0, 32'h4,        1, 32'h2001_0005,32'h4,        32'h8,        0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  1, 32'h8,        0, 32'h2001_0005,32'h4,        32'h8,        0));
        // ihit delayed three cycles; garbage on iload and redirect/halt must not matter
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 32'hDEAD_BEEF, 1, 1, 1, 32'h400, 1, 1, 32'h8,      0, 32'h2001_0005,32'h4,        32'h8,        0));
        vecs.push_back(mk(0, 1, 32'h8C22_0004,0, 0, 0, 32'h0,        0,  0, 32'h8,        1, 32'h8C22_0004,32'h8,        32'hC,        0));
        // data-memory stall with a stray ihit
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 1, 0, 0, 32'h0,   0,  0, 32'h8,        1, 32'h8C22_0004,32'h8,        32'hC,        0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 1, 0, 32'h0,        0,  1, 32'hC,        0, 32'h8C22_0004,32'h8,        32'hC,        0));
        vecs.push_back(mk(0, 1, 32'h1000_0010,0, 0, 0, 32'h0,        0,  0, 32'hC,        1, 32'h1000_0010,32'hC,        32'h10,       0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h0000_0103,0,  1, 32'h100,      0, 32'h1000_0010,32'hC,        32'h10,       0));
        vecs.push_back(mk(0, 1, 32'h3C00_FFFF,0, 0, 0, 32'h0,        0,  0, 32'h100,      1, 32'h3C00_FFFF,32'h100,      32'h104,      0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'hFFFF_FFFE,0,  1, 32'hFFFF_FFFC,0, 32'h3C00_FFFF,32'h100,      32'h104,      0));
        vecs.push_back(mk(0, 1, 32'h0800_0000,0, 0, 0, 32'h0,        0,  0, 32'hFFFF_FFFC,1, 32'h0800_0000,32'hFFFF_FFFC,32'h0,        0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0,  1, 32'h0,        0, 32'h0800_0000,32'hFFFF_FFFC,32'h0,        0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFF,0, 0, 0, 32'h0,        0,  0, 32'h0,        1, 32'hFFFF_FFFF,32'h0,        32'h4,        0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h200,      1,  0, 32'h0,        0, 32'hFFFF_FFFF,32'h0,        32'h4,        1));
        vecs.push_back(mk(0, 1, 32'h1111_1111,0, 1, 1, 32'h300,      0,  0, 32'h0,        0, 32'hFFFF_FFFF,32'h0,        32'h4,        1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h0,        0,  1, 32'h0,        0, 32'h0,        32'h0,        32'h4,        0));
        vecs.push_back(mk(0, 1, 32'h1234_5678,0, 0, 0, 32'h0,        0,  0, 32'h0,        1, 32'h1234_5678,32'h0,        32'h4,        0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0,        1,  0, 32'h0,        1, 32'h1234_5678,32'h0,        32'h4,        0));
        // reset during a data-memory stall, with dhit arriving in the same cycle
        vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h500,      1,  1, 32'h0,        0, 32'h0,        32'h0,        32'h4,        0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ihit, vecs[i].iload, vecs[i].dreq, vecs[i].dhit,
                  vecs[i].redir, vecs[i].rpc, vecs[i].halt);
            step();
            chk($sformatf("v%0d imemREN", i),     32'(imemREN),     32'(vecs[i].e_ren));
            chk($sformatf("v%0d imemaddr", i),    imemaddr,         vecs[i].e_addr);
            chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d Instr", i),       Instr,            vecs[i].e_instr);
            chk($sformatf("v%0d pc_out", i),      pc_out,           vecs[i].e_pc);
            chk($sformatf("v%0d npc_out", i),     npc_out,          vecs[i].e_npc);
            chk($sformatf("v%0d halted", i),      32'(halted),      32'(vecs[i].e_halted));
        end

        // back-to-back instructions with immediate ihit: valid alternates, PC steps by 4
        drive(0, 1, 32'h2001_0005, 0, 0, 0, '0, 0);
        exp_pc = 32'h0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k % 2 == 0) begin
                chk($sformatf("seq%0d valid", k), 32'(instr_valid), 32'd1);
                chk($sformatf("seq%0d pc_out", k), pc_out, exp_pc);
            end else begin
                exp_pc = exp_pc + 32'd4;
                chk($sformatf("seq%0d valid", k), 32'(instr_valid), 32'd0);
                chk($sformatf("seq%0d imemaddr", k), imemaddr, exp_pc);
            end
        end

        // bounded wait for an instruction after a delayed ihit
        found = 0;
        for (int c = 0; c < 8 && !found; c++) begin
            ihit  = (c >= 2);
            iload = 32'hCAFE_0001;
            step();
            if (instr_valid) found = 1;
        end
        chk("wait instr_valid", 32'(found), 32'd1);
        chk("wait Instr", Instr, 32'hCAFE_0001);
        chk("wait pc_out", pc_out, 32'hC);

`ifdef FETCH_STATS_EN
        drive(1, 0, '0, 0, 0, 0, '0, 0);
        step();
        chk("stats reset retired", retired_cnt, 32'd0);
        chk("stats reset stall", stall_cnt, 32'd0);
        drive(0, 0, '0, 0, 0, 0, '0, 0);
        repeat (3) step();
        ihit = 1;
        step();
        chk("stats fetch stall", stall_cnt, 32'd3);
        drive(0, 0, '0, 1, 0, 0, '0, 0);
        step();
        dhit = 1;
        step();
        chk("stats exec stall", stall_cnt, 32'd4);
        chk("stats retired", retired_cnt, 32'd1);
        drive(0, 1, 32'hFFFF_FFFF, 0, 0, 0, '0, 0);
        step();
        halt = 1;
        step();
        chk("stats halt retired", retired_cnt, 32'd2);
        halt = 0; ihit = 0;
        repeat (2) step();
        chk("stats frozen retired", retired_cnt, 32'd2);
        chk("stats frozen stall", stall_cnt, 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
